usb2_buf_copy_ctrl: RTL and testbench
=====================================

// Module: usb2_buf_copy_ctrl
// PURPOSE
// - Sequencer that copies one packet from a source endpoint buffer (BRAM read port) into a
//   destination endpoint buffer (BRAM write port), then pulses the destination's xfer_in.
// - Sits in the USB 2.0 protocol layer between the bulk OUT endpoint (EP2) and bulk IN (EP1).
// - Owns the source read address and destination write port for the copy's duration.
// - Streams at 1 byte/clk.
// PARAMETERS
// - ADDR_W   9    buffer address width (512-byte endpoint buffers)
// - LEN_W    10   width of packet length inputs (matches buf_out_len)
// - MAX_LEN  512  largest legal copy; longer requests are clamped
// - RD_LAT   2    source BRAM read latency in clocks, addr->q (>=1)
// PORTS
// - phy_clk      in   1       clock
// - reset        in   1       synchronous, active-high reset
// - req          in   1       start copy; sampled only in IDLE
// - src_len      in   LEN_W   byte count, sampled with req
// - dst_ready    in   1       destination free; copy waits in WAIT_DST while low
// - abort        in   1       cancel copy in progress
// - src_rd_addr  out  ADDR_W  source read address
// - src_rd_q     in   8       source read data, valid RD_LAT clks after address
// - dst_wr_addr  out  ADDR_W  destination write address
// - dst_wr_data  out  8       destination write data
// - dst_wr_en    out  1       destination write strobe
// - dst_commit   out  1       1-clk pulse: packet ready; drives destination xfer_in
// - busy         out  1       copy in progress
// - done         out  1       1-clk pulse, coincident with dst_commit
// - err_len      out  1       sticky: a request had src_len > MAX_LEN; cleared only by reset
// - cksum        out  8       only when USB2_COPY_CKSUM_EN is defined
// BEHAVIOUR
// - Reset: state=IDLE; all outputs 0 (addresses, data, strobes, busy, done, err_len, cksum).
//   A reset mid-copy kills it: no commit, and no further writes from the next clock.
// - States: IDLE -> WAIT_DST -> READ -> DRAIN -> COMMIT -> IDLE.
// - IDLE: on req, latch len = min(src_len, MAX_LEN).
//   - If src_len > MAX_LEN, also set err_len.
//   - Go to WAIT_DST. busy=1 from the next clock.
// - WAIT_DST: when dst_ready=1, zero the read counter and go to READ. Otherwise hold.
//   - If len==0, go straight to COMMIT (zero-length packet, no writes).
// - READ: src_rd_addr = 0,1,...,len-1 on consecutive clocks.
//   - A RD_LAT-deep valid shift register tags each issued address.
//   - After the last address, go to DRAIN.
// - Write pipeline: when a valid tag exits the shift register, assert dst_wr_en with
//   dst_wr_data=src_rd_q. dst_wr_addr equals the matching read address.
// - DRAIN: wait until the shift register is empty (RD_LAT clks), then go to COMMIT.
// - COMMIT: dst_commit=1 and done=1 for exactly 1 clk, then IDLE. busy falls the following clock.
// - Latency (dst_ready already 1, len=N>0):
//   - req at clock 0; first address at clock 2; first write at 2+RD_LAT.
//   - Last write at 1+N+RD_LAT; commit at 2+N+RD_LAT.
// - Counters are LEN_W wide. The address is the counter's low ADDR_W bits; it never wraps
//   because len <= MAX_LEN.
// - req while busy: ignored, not queued.
// - abort (any non-IDLE state): IDLE next clock.
//   - In-flight valid tags are flushed; dst_wr_en is 0 from the next clock.
//   - No commit/done. busy falls the next clock.
//   - abort and req in the same IDLE clock: abort wins, request dropped.
// - dst_ready falling during READ/DRAIN: ignored; the copy completes.
// CONFIGURATION
// - USB2_COPY_CKSUM_EN defined:
//   - cksum port exists; cleared on entering READ.
//   - Accumulates the 8-bit modulo-256 sum of every written byte.
//   - Holds its value from COMMIT until the next copy starts.
// - Undefined: no cksum port and no adder logic; everything else is identical.
// TESTING
// - len=4, RD_LAT=2, src bytes 11,22,33,44:
//   - writes at clocks 4..7 to addr 0..3 with those bytes; commit+done at clock 8;
//   - busy high clocks 1..8. With _EN, cksum=0xAA.
// - len=512, src[i]=i[7:0]: 512 consecutive writes, last addr 511 data 0xFF, single commit.
//   err_len=0.
// - src_len=600: exactly 512 writes, err_len=1 and still 1 after the next normal copy.
// - len=0: no dst_wr_en; commit 2 clks after dst_ready=1.
// - dst_ready=0 for 10 clks after req: no reads/writes; copy starts 1 clk after dst_ready rises.
// - abort after 3rd write of len=8: at most RD_LAT+1 writes total issued, no commit.
//   A following req copies normally.

Source files
------------

// File: rtl/usb2_buf_copy_ctrl.sv
// usb2_buf_copy_ctrl
// Copies one packet from a source endpoint buffer (BRAM read port) into a
// destination endpoint buffer (BRAM write port) at one byte per clock, then
// pulses dst_commit (destination xfer_in) together with done.
//
// Interface handshake:
//   req is a level sampled only in IDLE, and src_len is captured with it.
//   Once busy, further req pulses are ignored and are not queued. dst_ready
//   gates the start of streaming only, so a later drop is ignored. abort
//   returns to IDLE on the next clock from any state and flushes pending writes.
//
// Optional feature: define USB2_COPY_CKSUM_EN to add the cksum output, which
// is the modulo-256 sum of every byte written by the current copy.
//
// dbg_state exposes the sequencer state for checkers and bring-up.
module usb2_buf_copy_ctrl #(
    parameter int ADDR_W  = 9,
    parameter int LEN_W   = 10,
    parameter int MAX_LEN = 512,
    parameter int RD_LAT  = 2
) (
    input  logic              phy_clk,
    input  logic              reset,
    input  logic              req,
    input  logic [LEN_W-1:0]  src_len,
    input  logic              dst_ready,
    input  logic              abort,
    output logic [ADDR_W-1:0] src_rd_addr,
    input  logic [7:0]        src_rd_q,
    output logic [ADDR_W-1:0] dst_wr_addr,
    output logic [7:0]        dst_wr_data,
    output logic              dst_wr_en,
    output logic              dst_commit,
    output logic              busy,
    output logic              done,
    output logic              err_len,
    output logic [2:0]        dbg_state
`ifdef USB2_COPY_CKSUM_EN
    ,
    output logic [7:0]        cksum
`endif
);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_WAIT_DST = 3'd1,
        S_READ     = 3'd2,
        S_DRAIN    = 3'd3,
        S_COMMIT   = 3'd4
    } state_t;

    localparam logic [LEN_W-1:0] MAX_LEN_V = LEN_W'(MAX_LEN);

    state_t              state_q;
    state_t              state_d;
    logic [LEN_W-1:0]    len_q;       // clamped packet length of this copy
    logic [LEN_W-1:0]    rd_cnt_q;    // next read address to issue
    logic [ADDR_W-1:0]   wr_cnt_q;    // next write address (writes are in order)
    logic [RD_LAT-1:0]   vld_q;       // one tag per read in flight; MSB = data present now
    logic [RD_LAT-1:0]   vld_shift;   // tags advanced by one clock, with a new one inserted
    logic                issue;       // a read address is presented this clock
    logic                start_ok;    // IDLE accepts a request this clock
    logic                enter_read;  // WAIT_DST moves to READ this clock
    logic                last_rd;     // the address presented now is the final one

    assign start_ok   = (state_q == S_IDLE) && req && !abort;
    assign enter_read = (state_q == S_WAIT_DST) && dst_ready && !abort && (len_q != '0);
    assign issue      = (state_q == S_READ) && !abort;
    assign last_rd    = (rd_cnt_q == (len_q - LEN_W'(1)));

    // Advance the read-tag pipeline; the oldest tag drops off the top.
    always_comb begin
        vld_shift = vld_q << 1;
        vld_shift = vld_shift | RD_LAT'(issue);
    end

    // State register.
    always_ff @(posedge phy_clk) begin
        if (reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: abort overrides everything outside IDLE.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (start_ok) begin
                    state_d = S_WAIT_DST;
                end
            end
            S_WAIT_DST: begin
                if (abort) begin
                    state_d = S_IDLE;
                end else if (dst_ready) begin
                    // A zero-length packet commits without touching either buffer.
                    state_d = (len_q == '0) ? S_COMMIT : S_READ;
                end
            end
            S_READ: begin
                if (abort) begin
                    state_d = S_IDLE;
                end else if (last_rd) begin
                    state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                // Leave once the last tag is exiting, so commit follows the final write.
                if (abort) begin
                    state_d = S_IDLE;
                end else if (vld_shift == '0) begin
                    state_d = S_COMMIT;
                end
            end
            S_COMMIT: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Request capture: clamp the length and record any oversize request.
    always_ff @(posedge phy_clk) begin
        if (reset) begin
            len_q   <= '0;
            err_len <= 1'b0;
        end else if (start_ok) begin
            len_q <= (src_len > MAX_LEN_V) ? MAX_LEN_V : src_len;
            if (src_len > MAX_LEN_V) begin
                err_len <= 1'b1;
            end
        end
    end

    // Read address counter; it restarts when streaming begins.
    always_ff @(posedge phy_clk) begin
        if (reset) begin
            rd_cnt_q <= '0;
        end else if (enter_read) begin
            rd_cnt_q <= '0;
        end else if (issue) begin
            rd_cnt_q <= rd_cnt_q + LEN_W'(1);
        end
    end

    // Tag pipeline matching the source read latency; abort flushes it.
    always_ff @(posedge phy_clk) begin
        if (reset) begin
            vld_q <= '0;
        end else if (abort) begin
            vld_q <= '0;
        end else begin
            vld_q <= vld_shift;
        end
    end

    // Write address counter; it advances on every byte written.
    always_ff @(posedge phy_clk) begin
        if (reset) begin
            wr_cnt_q <= '0;
        end else if (enter_read) begin
            wr_cnt_q <= '0;
        end else if (dst_wr_en) begin
            wr_cnt_q <= wr_cnt_q + ADDR_W'(1);
        end
    end

`ifdef USB2_COPY_CKSUM_EN
    logic [7:0] cksum_q;

    // Running byte sum: cleared on entering READ and held after the copy ends.
    always_ff @(posedge phy_clk) begin
        if (reset) begin
            cksum_q <= 8'h00;
        end else if (enter_read) begin
            cksum_q <= 8'h00;
        end else if (dst_wr_en) begin
            cksum_q <= cksum_q + dst_wr_data;
        end
    end

    assign cksum = cksum_q;
`endif

    // Output decode. Write data is forced to zero when no write is strobed.
    always_comb begin
        src_rd_addr = rd_cnt_q[ADDR_W-1:0];
        dst_wr_en   = vld_q[RD_LAT-1];
        dst_wr_addr = wr_cnt_q;
        dst_wr_data = dst_wr_en ? src_rd_q : 8'h00;
        busy        = (state_q != S_IDLE);
        dst_commit  = (state_q == S_COMMIT);
        done        = (state_q == S_COMMIT);
        dbg_state   = state_q;
    end

endmodule

// File: tb/tb_usb2_buf_copy_ctrl.sv
// tb_usb2_buf_copy_ctrl
// Scoreboard bench for usb2_buf_copy_ctrl. The driver predicts every write
// (cycle, address, byte) and every commit (cycle, cksum, err_len) from the
// packet length and the source buffer contents, and pushes them into queues.
// A monitor on the falling edge pops and compares whenever the DUT strobes a
// write or a commit.
`timescale 1ns/1ps
module tb_usb2_buf_copy_ctrl;

    localparam int ADDR_W  = 9;
    localparam int LEN_W   = 10;
    localparam int MAX_LEN = 512;
    localparam int RD_LAT  = 2;

    logic              phy_clk = 1'b0;
    logic              reset;
    logic              req;
    logic [LEN_W-1:0]  src_len;
    logic              dst_ready;
    logic              abort;
    logic [ADDR_W-1:0] src_rd_addr;
    logic [7:0]        src_rd_q;
    logic [ADDR_W-1:0] dst_wr_addr;
    logic [7:0]        dst_wr_data;
    logic              dst_wr_en;
    logic              dst_commit;
    logic              busy;
    logic              done;
    logic              err_len;
    logic [2:0]        dbg_state;
`ifdef USB2_COPY_CKSUM_EN
    logic [7:0]        cksum;
`endif

    usb2_buf_copy_ctrl #(
        .ADDR_W(ADDR_W), .LEN_W(LEN_W), .MAX_LEN(MAX_LEN), .RD_LAT(RD_LAT)
    ) dut (
        .phy_clk(phy_clk), .reset(reset), .req(req), .src_len(src_len),
        .dst_ready(dst_ready), .abort(abort), .src_rd_addr(src_rd_addr),
        .src_rd_q(src_rd_q), .dst_wr_addr(dst_wr_addr), .dst_wr_data(dst_wr_data),
        .dst_wr_en(dst_wr_en), .dst_commit(dst_commit), .busy(busy), .done(done),
        .err_len(err_len), .dbg_state(dbg_state)
`ifdef USB2_COPY_CKSUM_EN
        , .cksum(cksum)
`endif
    );

    // ---------------- clock / cycle counter ----------------
    always #5 phy_clk = ~phy_clk;

    int cyc = 0;
    always @(posedge phy_clk) cyc <= cyc + 1;

    // ---------------- source BRAM model ----------------
    logic [7:0] mem [512];
    logic [7:0] pipe [RD_LAT];

    always @(posedge phy_clk) begin
        pipe[0] <= mem[src_rd_addr];
        for (int i = 1; i < RD_LAT; i++) pipe[i] <= pipe[i-1];
    end
    assign src_rd_q = pipe[RD_LAT-1];

    // ---------------- scoreboard state ----------------
    logic [48:0] exp_q [$];   // {cycle[31:0], addr[8:0], data[7:0]}
    logic [40:0] cmt_q [$];   // {cycle[31:0], cksum[7:0], err_len}
    int          n_cmp = 0;
    int          n_bad = 0;
    bit          abort_mode = 1'b0;
    int          ab_cnt = 0;
    logic [7:0]  ab_sum = 8'h00;
    bit          err_m = 1'b0;     // model of sticky err_len
    logic [7:0]  ck_m = 8'h00;     // model of cksum register

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- monitor ----------------
    always @(negedge phy_clk) begin
        if (!reset) begin
            if (dst_wr_en) begin
                if (abort_mode) begin
                    ab_cnt++;
                    ab_sum = ab_sum + dst_wr_data;
                    check("abort_wr_data", dst_wr_data, mem[dst_wr_addr]);
                end else if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL unexpected_write: addr %0d data %0h at cycle %0d, none expected",
                             dst_wr_addr, dst_wr_data, cyc);
                end else begin
                    logic [48:0] e;
                    e = exp_q.pop_front();
                    check("wr_cycle", 64'(cyc), 64'(e[48:17]));
                    check("wr_addr", 64'(dst_wr_addr), 64'(e[16:8]));
                    check("wr_data", 64'(dst_wr_data), 64'(e[7:0]));
                end
            end
            if (done !== dst_commit) begin
                n_cmp++;
                n_bad++;
                $display("FAIL done_vs_commit: done=%0b commit=%0b at cycle %0d, must match",
                         done, dst_commit, cyc);
            end
            if (dst_commit) begin
                if (cmt_q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL unexpected_commit: commit at cycle %0d, none expected", cyc);
                end else begin
                    logic [40:0] c;
                    c = cmt_q.pop_front();
                    check("commit_cycle", 64'(cyc), 64'(c[40:9]));
                    check("commit_err_len", 64'(err_len), 64'(c[0]));
                    check("writes_left_at_commit", 64'(exp_q.size()), 64'd0);
`ifdef USB2_COPY_CKSUM_EN
                    check("cksum", 64'(cksum), 64'(c[8:1]));
`endif
                end
            end
        end
    end

    // ---------------- driver ----------------
    // kind: 0 normal, 1 abort after ab_after writes, 2 reset after ab_after writes
    task automatic do_copy(input int len, input int dly, input int kind, input int ab_after,
                           input bit keep_mem);
        int         eff;
        int         base;
        int         w;
        bit         seen;
        logic [7:0] sum;
        @(negedge phy_clk);
        if (!keep_mem) begin
            for (int i = 0; i < 512; i++) mem[i] = 8'($urandom_range(0, 255));
        end
        eff = (len > MAX_LEN) ? MAX_LEN : len;
        if (len > MAX_LEN) err_m = 1'b1;
        base = cyc + dly + 2;   // cycle the first read address appears
        if (kind == 0) begin
            sum = 8'h00;
            for (int i = 0; i < eff; i++) begin
                exp_q.push_back({32'(base + RD_LAT + i), 9'(i), mem[i]});
                sum = sum + mem[i];
            end
            if (eff > 0) ck_m = sum;
            cmt_q.push_back({32'(base + ((eff > 0) ? (eff + RD_LAT) : 0)), ck_m, err_m});
        end else begin
            abort_mode = 1'b1;
            ab_cnt = 0;
            ab_sum = 8'h00;
        end
        req = 1'b1;
        src_len = LEN_W'(len);
        dst_ready = (dly == 0);
        // A stray request while busy must be ignored.
        for (int k = 1; k <= dly + 1; k++) begin
            @(negedge phy_clk);
            req = (k == 1);
            if (k == 1) src_len = LEN_W'($urandom_range(1, 700));
            dst_ready = (k == dly + 1);
        end
        if (kind == 0) begin
            seen = 1'b0;
            for (int t = 0; t < 3000; t++) begin
                @(negedge phy_clk);
                req = 1'b0;
                dst_ready = 1'($urandom_range(0, 1));
                if (dst_commit) begin
                    seen = 1'b1;
                    check("busy_at_commit", 64'(busy), 64'd1);
                    break;
                end
            end
            if (!seen) begin
                n_cmp++;
                n_bad++;
                $display("FAIL commit_timeout: no commit within 3000 cycles for len %0d", len);
            end
            @(negedge phy_clk);
            check("busy_after_commit", 64'(busy), 64'd0);
        end else begin
            w = 0;
            seen = 1'b0;
            for (int t = 0; t < 3000; t++) begin
                @(negedge phy_clk);
                req = 1'b0;
                if (dst_wr_en) w++;
                if (w == ab_after) begin
                    seen = 1'b1;
                    if (kind == 1) abort = 1'b1;
                    else reset = 1'b1;
                    break;
                end
            end
            if (!seen) begin
                n_cmp++;
                n_bad++;
                $display("FAIL abort_timeout: write %0d never seen", ab_after);
            end
            @(negedge phy_clk);
            abort = 1'b0;
            check("busy_after_kill", 64'(busy), 64'd0);
            check("wr_en_after_kill", 64'(dst_wr_en), 64'd0);
            if (kind == 2) begin
                check("err_len_after_reset", 64'(err_len), 64'd0);
                reset = 1'b0;
                err_m = 1'b0;
                ck_m = 8'h00;
            end
            repeat (RD_LAT + 3) @(negedge phy_clk);
            check("writes_after_kill_bounded", 64'(ab_cnt <= RD_LAT + 1), 64'd1);
            if (kind == 1) ck_m = ab_sum;
            abort_mode = 1'b0;
        end
    endtask

    // ---------------- main sequence ----------------
    initial begin
        for (int i = 0; i < RD_LAT; i++) pipe[i] = 8'h00;
        for (int i = 0; i < 512; i++) mem[i] = 8'h00;
        reset = 1'b1;
        req = 1'b0;
        abort = 1'b0;
        dst_ready = 1'b0;
        src_len = '0;
        repeat (3) @(negedge phy_clk);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_wr_en", 64'(dst_wr_en), 64'd0);
        check("rst_commit", 64'(dst_commit), 64'd0);
        check("rst_err_len", 64'(err_len), 64'd0);
        check("rst_addrs", 64'({src_rd_addr, dst_wr_addr, dst_wr_data}), 64'd0);
`ifdef USB2_COPY_CKSUM_EN
        check("rst_cksum", 64'(cksum), 64'd0);
`endif
        reset = 1'b0;
        repeat (2) @(negedge phy_clk);

        // Four bytes 11,22,33,44: writes at clocks 4..7, commit at 8, sum 0xAA.
        for (int i = 0; i < 512; i++) mem[i] = 8'($urandom_range(0, 255));
        mem[0] = 8'h11; mem[1] = 8'h22; mem[2] = 8'h33; mem[3] = 8'h44;
        do_copy(4, 0, 0, 0, 1'b1);
        check("cksum_model_aa", 64'(ck_m), 64'h0AA);

        // Full-size packet with an incrementing pattern.
        for (int i = 0; i < 512; i++) mem[i] = 8'(i);
        do_copy(512, 0, 0, 0, 1'b1);
        check("err_len_after_512", 64'(err_len), 64'd0);

        // Oversize request: clamped, sticky error survives a normal copy.
        do_copy(600, 0, 0, 0, 1'b0);
        do_copy(10, 0, 0, 0, 1'b0);
        check("err_len_sticky", 64'(err_len), 64'd1);

        // Zero-length packet and a destination that stays busy for 10 clocks.
        do_copy(0, 0, 0, 0, 1'b0);
        do_copy(5, 10, 0, 0, 1'b0);

        // Abort after the third write, then a normal copy.
        do_copy(8, 0, 1, 3, 1'b0);
        do_copy(8, 0, 0, 0, 1'b0);

        // Reset in the middle of a copy.
        do_copy(20, 2, 2, 2, 1'b0);

        // abort and req in the same IDLE clock: the request is dropped.
        @(negedge phy_clk);
        req = 1'b1;
        abort = 1'b1;
        src_len = LEN_W'(600);
        @(negedge phy_clk);
        req = 1'b0;
        abort = 1'b0;
        check("idle_abort_busy", 64'(busy), 64'd0);
        check("idle_abort_err_len", 64'(err_len), 64'(err_m));
        repeat (6) @(negedge phy_clk);

        // Randomized copies.
        for (int n = 0; n < 20; n++) begin
            int len;
            len = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, 8))
                                              : int'($urandom_range(0, 700));
            do_copy(len, int'($urandom_range(0, 5)), 0, 0, 1'b0);
        end

        repeat (5) @(negedge phy_clk);
        check("write_queue_drained", 64'(exp_q.size()), 64'd0);
        check("commit_queue_drained", 64'(cmt_q.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
